// File: rtl/pkt256_rx_unpacker.sv
// pkt256_rx_unpacker
//
// Consumer side of the 256-bit Aurora RX packet FIFO. Pops one packet at a time from a
// first-word-fall-through FIFO, decodes the header, filters on BS_ID and payload length,
// checks PCKG_ID continuity and streams the valid 32-bit payload words downstream.
//
// Head word layout:
//   BS_ID[255:248] FPGA_ID[247:240] PCKG_ID[239:224] TX_UID[223:216] RX_UID[215:208]
//   VALID_PACKET_BYTES[207:192] msg0[191:160] msg1[159:128] ... msg5[31:0]
//
// Ports:
//   clk_200MHz          in   single clock
//   peripheral_aresetn  in   asynchronous active-low reset (sync release inside)
//   fifo_dout           in   FWFT head word
//   fifo_not_empty      in   head word valid
//   fifo_rd_en          out  pop strobe (combinational)
//   hdr_valid           out  one-cycle pulse, hdr_* valid
//   hdr_pckg_id/tx_uid/rx_uid/bytes  out  header fields of the accepted packet
//   m_data/m_valid/m_last  out, m_ready in  payload stream
//   seq_err             out  one-cycle pulse on a PCKG_ID discontinuity
//   pkt_count/drop_count/seq_err_count  out  saturating statistics
//
// Optional feature: define PKT_RX_FPGA_ID_FILTER_EN to additionally require
// FPGA_ID == LOCAL_FPGA_ID for non-broadcast packets.

module pkt256_rx_unpacker #(
    parameter logic [7:0]  LOCAL_BS_ID   = 8'h02,
    parameter logic [7:0]  BCAST_BS_ID   = 8'hFF,
    parameter logic [7:0]  LOCAL_FPGA_ID = 8'h00,
    // The head word has room for exactly six payload slots.
    parameter int unsigned MAX_MSGS      = 6
) (
    input  logic         clk_200MHz,
    input  logic         peripheral_aresetn,
    input  logic [255:0] fifo_dout,
    input  logic         fifo_not_empty,
    output logic         fifo_rd_en,
    output logic         hdr_valid,
    output logic [15:0]  hdr_pckg_id,
    output logic [7:0]   hdr_tx_uid,
    output logic [7:0]   hdr_rx_uid,
    output logic [15:0]  hdr_bytes,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         seq_err,
    output logic [31:0]  pkt_count,
    output logic [15:0]  drop_count,
    output logic [15:0]  seq_err_count
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDecode = 2'd1;
    localparam logic [1:0] StStream = 2'd2;

    localparam logic [15:0] MaxBytes = 16'(MAX_MSGS * 4);

    // Reset synchroniser: assertion is immediate, release is aligned to the clock.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [1:0]   state_q, state_d;
    logic [7:0]   bs_id_q;
    logic [15:0]  pckg_id_q;
    logic [7:0]   tx_uid_q;
    logic [7:0]   rx_uid_q;
    logic [15:0]  bytes_q;
    logic [191:0] msg_q;
    logic [2:0]   idx_q, idx_d;
    logic [2:0]   word_cnt_q, word_cnt_d;
    logic [15:0]  expected_id_q, expected_id_d;
    logic         seq_synced_q, seq_synced_d;
    logic [31:0]  pkt_count_q, pkt_count_d;
    logic [15:0]  drop_count_q, drop_count_d;
    logic [15:0]  seq_err_count_q, seq_err_count_d;

    logic pop;
    logic in_decode;
    logic in_stream;
    logic bs_ok;
    logic fpga_ok;
    logic len_ok;
    logic accept;
    logic [31:0] cur_word;

    // Both reset terms gate the pop so no word is consumed before the state
    // registers have left reset.
    assign pop        = (state_q == StIdle) & fifo_not_empty & peripheral_aresetn & rst_n;
    assign fifo_rd_en = pop;

    assign in_decode = (state_q == StDecode);
    assign in_stream = (state_q == StStream);

`ifdef PKT_RX_FPGA_ID_FILTER_EN
    logic [7:0] fpga_id_q;

    always_ff @(posedge clk_200MHz or negedge rst_n) begin
        if (!rst_n) begin
            fpga_id_q <= 8'h00;
        end else if (pop) begin
            fpga_id_q <= fifo_dout[247:240];
        end
    end

    // Broadcast packets ignore FPGA_ID.
    assign fpga_ok = (fpga_id_q == LOCAL_FPGA_ID) | (bs_id_q == BCAST_BS_ID);
`else
    logic unused_fpga_id;
    assign unused_fpga_id = ^{fifo_dout[247:240], LOCAL_FPGA_ID};
    assign fpga_ok        = 1'b1;
`endif

    assign bs_ok  = (bs_id_q == LOCAL_BS_ID) | (bs_id_q == BCAST_BS_ID);
    assign len_ok = (bytes_q[1:0] == 2'b00) & (bytes_q <= MaxBytes);
    assign accept = bs_ok & fpga_ok & len_ok;

    assign hdr_valid   = in_decode & accept;
    assign seq_err     = hdr_valid & seq_synced_q & (pckg_id_q != expected_id_q);
    assign hdr_pckg_id = pckg_id_q;
    assign hdr_tx_uid  = tx_uid_q;
    assign hdr_rx_uid  = rx_uid_q;
    assign hdr_bytes   = bytes_q;

    always_comb begin
        cur_word = 32'h0;
        case (idx_q)
            3'd0:    cur_word = msg_q[191:160];
            3'd1:    cur_word = msg_q[159:128];
            3'd2:    cur_word = msg_q[127:96];
            3'd3:    cur_word = msg_q[95:64];
            3'd4:    cur_word = msg_q[63:32];
            3'd5:    cur_word = msg_q[31:0];
            default: cur_word = 32'h0;
        endcase
    end

    assign m_valid = in_stream;
    assign m_data  = in_stream ? cur_word : 32'h0;
    assign m_last  = in_stream & (idx_q == (word_cnt_q - 3'd1));

    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign seq_err_count = seq_err_count_q;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        word_cnt_d      = word_cnt_q;
        expected_id_d   = expected_id_q;
        seq_synced_d    = seq_synced_q;
        pkt_count_d     = pkt_count_q;
        drop_count_d    = drop_count_q;
        seq_err_count_d = seq_err_count_q;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StDecode;
                end
            end

            StDecode: begin
                if (accept) begin
                    if (pkt_count_q != 32'hFFFF_FFFF) begin
                        pkt_count_d = pkt_count_q + 32'd1;
                    end
                    if (seq_err && (seq_err_count_q != 16'hFFFF)) begin
                        seq_err_count_d = seq_err_count_q + 16'd1;
                    end
                    expected_id_d = pckg_id_q + 16'd1;
                    seq_synced_d  = 1'b1;
                    if (bytes_q == 16'h0000) begin
                        state_d = StIdle;
                    end else begin
                        // Length already checked: bytes <= 24, so bits [4:2] hold the word count.
                        word_cnt_d = bytes_q[4:2];
                        idx_d      = 3'd0;
                        state_d    = StStream;
                    end
                end else begin
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end

            StStream: begin
                if (m_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (m_last) begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_200MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            idx_q           <= 3'd0;
            word_cnt_q      <= 3'd0;
            expected_id_q   <= 16'h0000;
            seq_synced_q    <= 1'b0;
            pkt_count_q     <= 32'h0;
            drop_count_q    <= 16'h0;
            seq_err_count_q <= 16'h0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            word_cnt_q      <= word_cnt_d;
            expected_id_q   <= expected_id_d;
            seq_synced_q    <= seq_synced_d;
            pkt_count_q     <= pkt_count_d;
            drop_count_q    <= drop_count_d;
            seq_err_count_q <= seq_err_count_d;
        end
    end

    // Packet register, loaded in the pop cycle.
    always_ff @(posedge clk_200MHz or negedge rst_n) begin
        if (!rst_n) begin
            bs_id_q   <= 8'h00;
            pckg_id_q <= 16'h0000;
            tx_uid_q  <= 8'h00;
            rx_uid_q  <= 8'h00;
            bytes_q   <= 16'h0000;
            msg_q     <= 192'h0;
        end else if (pop) begin
            bs_id_q   <= fifo_dout[255:248];
            pckg_id_q <= fifo_dout[239:224];
            tx_uid_q  <= fifo_dout[223:216];
            rx_uid_q  <= fifo_dout[215:208];
            bytes_q   <= fifo_dout[207:192];
            msg_q     <= fifo_dout[191:0];
        end
    end

endmodule

// File: tb/tb_pkt256_rx_unpacker.sv
// Testbench for pkt256_rx_unpacker: FWFT FIFO model, negedge monitor, a table of
// single-packet vectors plus hand-written sequences for throughput, stalls and reset.
`timescale 1ns/1ps

module tb_pkt256_rx_unpacker;

    logic         clk_200MHz = 1'b0;
    logic         peripheral_aresetn = 1'b0;
    logic [255:0] fifo_dout = '0;
    logic         fifo_not_empty = 1'b0;
    logic         fifo_rd_en;
    logic         hdr_valid;
    logic [15:0]  hdr_pckg_id;
    logic [7:0]   hdr_tx_uid;
    logic [7:0]   hdr_rx_uid;
    logic [15:0]  hdr_bytes;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         m_last;
    logic         seq_err;
    logic [31:0]  pkt_count;
    logic [15:0]  drop_count;
    logic [15:0]  seq_err_count;

`ifdef PKT_RX_FPGA_ID_FILTER_EN
    localparam bit FpgaFilt = 1'b1;
`else
    localparam bit FpgaFilt = 1'b0;
`endif

    always #2.5 clk_200MHz = ~clk_200MHz;

    pkt256_rx_unpacker dut (
        .clk_200MHz         (clk_200MHz),
        .peripheral_aresetn (peripheral_aresetn),
        .fifo_dout          (fifo_dout),
        .fifo_not_empty     (fifo_not_empty),
        .fifo_rd_en         (fifo_rd_en),
        .hdr_valid          (hdr_valid),
        .hdr_pckg_id        (hdr_pckg_id),
        .hdr_tx_uid         (hdr_tx_uid),
        .hdr_rx_uid         (hdr_rx_uid),
        .hdr_bytes          (hdr_bytes),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_last             (m_last),
        .seq_err            (seq_err),
        .pkt_count          (pkt_count),
        .drop_count         (drop_count),
        .seq_err_count      (seq_err_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_pkt(input logic [7:0] bs, input logic [7:0] fpga,
                                            input logic [15:0] id, input logic [7:0] tx,
                                            input logic [7:0] rx, input logic [15:0] bytes,
                                            input logic [31:0] seed, input bit inc);
        logic [255:0] p;
        p = '0;
        p[255:248] = bs;
        p[247:240] = fpga;
        p[239:224] = id;
        p[223:216] = tx;
        p[215:208] = rx;
        p[207:192] = bytes;
        for (int k = 0; k < 6; k++) begin
            p[191-32*k -: 32] = inc ? seed + 32'(k) : seed;
        end
        return p;
    endfunction

    // FWFT FIFO model: pop decided from rd_en seen at the previous negedge.
    logic [255:0] fifo_q[$];
    bit           pop_pending = 1'b0;
    bit           stall_mode  = 1'b0;
    int           ph          = 0;

    initial begin
        forever begin
            @(posedge clk_200MHz);
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #1;
            fifo_not_empty = (fifo_q.size() > 0);
            fifo_dout      = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            m_ready        = stall_mode ? ((ph % 3) == 0) : 1'b1;
            ph++;
        end
    end

    // Monitor
    int          cyc = 0, pops = 0, hv = 0, serr = 0, stab_err = 0, rd_in_stream = 0;
    int          stall_cyc = 0, pop_cyc = 0, hdr_cyc = 0, first_mv_cyc = 0, last_xfer_cyc = 0;
    logic [15:0] h_id = '0, h_bytes = '0;
    logic [7:0]  h_tx = '0, h_rx = '0;
    logic [31:0] xd[$];
    bit          xl[$];
    logic        prev_mv = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    initial begin
        forever begin
            @(negedge clk_200MHz);
            cyc++;
            pop_pending = fifo_rd_en;
            if (fifo_rd_en) begin
                pops++;
                pop_cyc = cyc;
            end
            if ((m_valid || hdr_valid) && fifo_rd_en) rd_in_stream++;
            if (hdr_valid) begin
                hv++;
                hdr_cyc = cyc;
                h_id    = hdr_pckg_id;
                h_tx    = hdr_tx_uid;
                h_rx    = hdr_rx_uid;
                h_bytes = hdr_bytes;
            end
            if (seq_err) serr++;
            if (m_valid && !prev_mv) first_mv_cyc = cyc;
            if (m_valid && !m_ready) stall_cyc++;
            if (prev_mv && !prev_rdy && peripheral_aresetn &&
                !(m_valid && m_data == prev_data && m_last == prev_last)) stab_err++;
            if (m_valid && m_ready) begin
                xd.push_back(m_data);
                xl.push_back(m_last);
                last_xfer_cyc = cyc;
            end
            prev_mv   = m_valid;
            prev_rdy  = m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    task automatic set_rst(input logic v);
        @(posedge clk_200MHz);
        #1;
        peripheral_aresetn = v;
    endtask

    // Wait for the FIFO to drain and the DUT to go quiet, bounded.
    task automatic run_quiet(input string nm);
        int idle = 0;
        int n    = 0;
        while (idle < 4 && n < 3000) begin
            @(negedge clk_200MHz);
            n++;
            if (fifo_q.size() == 0 && !fifo_rd_en && !m_valid && !hdr_valid) idle++;
            else idle = 0;
        end
        if (idle < 4) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, n);
        end
    endtask

    typedef struct {
        logic [7:0]  bs;
        logic [7:0]  fpga;
        logic [15:0] id;
        logic [15:0] bytes;
        bit          acc;
        bit          serr;
        int          words;
    } vec_t;

    vec_t vt[12];

    initial begin
        int hv0, serr0, pops0, stab0, rds0, stall0, bd, bl, e_pkt, e_drop, e_serr, n;
        logic [31:0] seed;

        vt[0]  = '{8'h03, 8'h00, 16'd0,      16'd8,  1'b0, 1'b0, 0};
        vt[1]  = '{8'hFF, 8'h00, 16'd0,      16'd8,  1'b1, 1'b0, 2};
        vt[2]  = '{8'h02, 8'h00, 16'd1,      16'd24, 1'b1, 1'b0, 6};
        vt[3]  = '{8'h02, 8'h00, 16'd5,      16'd4,  1'b1, 1'b1, 1};
        vt[4]  = '{8'h02, 8'h00, 16'd6,      16'd0,  1'b1, 1'b0, 0};
        vt[5]  = '{8'h02, 8'h00, 16'd7,      16'd10, 1'b0, 1'b0, 0};
        vt[6]  = '{8'h02, 8'h00, 16'd7,      16'd28, 1'b0, 1'b0, 0};
        vt[7]  = '{8'h02, 8'h00, 16'hFFFF,   16'd4,  1'b1, 1'b1, 1};
        vt[8]  = '{8'h02, 8'h00, 16'h0000,   16'd4,  1'b1, 1'b0, 1};
        vt[9]  = '{8'h02, 8'h01, 16'd1,      16'd8,  !FpgaFilt, 1'b0, FpgaFilt ? 0 : 2};
        vt[10] = '{8'hFF, 8'h01, 16'd50,     16'd12, 1'b1, 1'b1, 3};
        vt[11] = '{8'h02, 8'h00, 16'd51,     16'd24, 1'b1, 1'b0, 6};

        // Reset state, with packets already waiting in the FIFO.
        for (int i = 0; i < 36; i++) begin
            fifo_q.push_back(mk_pkt(8'h02, 8'h00, 16'(i), 8'h11, 8'h22, 16'd24, 32'd1, 1'b0));
        end
        repeat (3) @(posedge clk_200MHz);
        @(negedge clk_200MHz);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_hdr_fields", {hdr_pckg_id, hdr_tx_uid, hdr_rx_uid, hdr_bytes}, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_counters", {pkt_count, drop_count, seq_err_count}, 0);

        // 36 back-to-back packets.
        hv0 = hv; serr0 = serr; pops0 = pops;
        xd.delete(); xl.delete();
        set_rst(1'b1);
        run_quiet("p36");
        chk("p36_hdr_pulses", hv - hv0, 36);
        chk("p36_pops", pops - pops0, 36);
        chk("p36_words", xd.size(), 216);
        bd = 0; bl = 0;
        foreach (xd[k]) begin
            if (xd[k] !== 32'd1) bd++;
            if (xl[k] != ((k % 6) == 5)) bl++;
        end
        chk("p36_bad_data", bd, 0);
        chk("p36_bad_last", bl, 0);
        chk("p36_cadence", last_xfer_cyc - pop_cyc, 7);
        chk("p36_seq_err_pulses", serr - serr0, 0);
        chk("p36_pkt_count", pkt_count, 36);
        chk("p36_drop_count", drop_count, 0);
        chk("p36_seq_err_count", seq_err_count, 0);

        // Table-driven single packets.
        set_rst(1'b0);
        repeat (2) @(posedge clk_200MHz);
        set_rst(1'b1);
        e_pkt = 0; e_drop = 0; e_serr = 0;
        for (int i = 0; i < 12; i++) begin
            hv0 = hv; serr0 = serr;
            xd.delete(); xl.delete();
            seed = 32'hC0DE_0000 + 32'(i << 8);
            fifo_q.push_back(mk_pkt(vt[i].bs, vt[i].fpga, vt[i].id, 8'hA0 + 8'(i),
                                    8'hB0 + 8'(i), vt[i].bytes, seed, 1'b1));
            run_quiet($sformatf("v%0d", i));
            e_pkt  += int'(vt[i].acc);
            e_drop += int'(!vt[i].acc);
            e_serr += int'(vt[i].serr);
            chk($sformatf("v%0d_hdr_valid", i), hv - hv0, 64'(vt[i].acc));
            chk($sformatf("v%0d_seq_err", i), serr - serr0, 64'(vt[i].serr));
            chk($sformatf("v%0d_words", i), xd.size(), vt[i].words);
            if (vt[i].acc) begin
                chk($sformatf("v%0d_hdr_fields", i), {h_id, h_tx, h_rx, h_bytes},
                    {vt[i].id, 8'hA0 + 8'(i), 8'hB0 + 8'(i), vt[i].bytes});
            end
            for (int k = 0; k < xd.size() && k < vt[i].words; k++) begin
                chk($sformatf("v%0d_data%0d", i, k), xd[k], seed + 32'(k));
                chk($sformatf("v%0d_last%0d", i, k), xl[k], 64'(k == vt[i].words - 1));
            end
            chk($sformatf("v%0d_counts", i), {pkt_count, drop_count, seq_err_count},
                {32'(e_pkt), 16'(e_drop), 16'(e_serr)});
        end

        // Backpressure: ready pattern 1,0,0 repeating, second packet queued behind.
        hv0 = hv; serr0 = serr; stab0 = stab_err; rds0 = rd_in_stream; stall0 = stall_cyc;
        xd.delete(); xl.delete();
        stall_mode = 1'b1;
        fifo_q.push_back(mk_pkt(8'h02, 8'h00, 16'd52, 8'h01, 8'h02, 16'd24, 32'h5A5A_0000, 1'b1));
        fifo_q.push_back(mk_pkt(8'h02, 8'h00, 16'd53, 8'h03, 8'h04, 16'd4, 32'h7777_0000, 1'b1));
        run_quiet("stall");
        stall_mode = 1'b0;
        chk("stall_exercised", 64'(stall_cyc - stall0 > 0), 1);
        chk("stall_words", xd.size(), 7);
        for (int k = 0; k < 6 && k < xd.size(); k++) begin
            chk($sformatf("stall_data%0d", k), xd[k], 32'h5A5A_0000 + 32'(k));
        end
        if (xd.size() == 7) chk("stall_data_pkt2", xd[6], 32'h7777_0000);
        chk("stall_hold_violations", stab_err - stab0, 0);
        chk("stall_pop_while_busy", rd_in_stream - rds0, 0);
        chk("stall_seq_err", serr - serr0, 0);

        // Reset asserted during the third word of a packet.
        xd.delete(); xl.delete();
        fifo_q.push_back(mk_pkt(8'h02, 8'h00, 16'd100, 8'h05, 8'h06, 16'd24, 32'h1000_0000, 1'b1));
        fifo_q.push_back(mk_pkt(8'h02, 8'h00, 16'd200, 8'h07, 8'h08, 16'd8, 32'h2000_0000, 1'b1));
        n = 0;
        do begin
            @(negedge clk_200MHz);
            #0.5;
            n++;
        end while (!(xd.size() == 2 && m_valid) && n < 200);
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL mrst_reach_word3: third word not seen, expected within 200 cycles");
        end
        peripheral_aresetn = 1'b0;
        #0.5;
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_m_data", m_data, 0);
        chk("mrst_m_last", m_last, 0);
        chk("mrst_rd_en", fifo_rd_en, 0);
        chk("mrst_counters", {pkt_count, drop_count, seq_err_count}, 0);
        pops0 = pops;
        repeat (3) @(negedge clk_200MHz);
        chk("mrst_no_pop_in_reset", pops - pops0, 0);
        hv0 = hv; serr0 = serr;
        xd.delete(); xl.delete();
        set_rst(1'b1);
        run_quiet("mrst");
        chk("mrst_hdr_valid", hv - hv0, 1);
        chk("mrst_hdr_id", h_id, 16'd200);
        chk("mrst_seq_err", serr - serr0, 0);
        chk("mrst_words", xd.size(), 2);
        if (xd.size() == 2) chk("mrst_data", {xd[0], xd[1]}, {32'h2000_0000, 32'h2000_0001});
        chk("mrst_pkt_count", pkt_count, 1);
        chk("mrst_hdr_latency", hdr_cyc - pop_cyc, 1);
        chk("mrst_data_latency", first_mv_cyc - pop_cyc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt256_rx_unpacker.md
Name: pkt256_rx_unpacker

Overview:
- Consumer side of the 256-bit packet FIFO at the Aurora user interface. Pops packets from a first-word-fall-through FIFO (dout/not_empty/rd_en) and decodes the header.
- Filters packets on BS_ID, checks PCKG_ID sequence, and streams the valid 32-bit payload messages out on a valid/ready interface.
- Sits between the RX FIFO and the local processing unit, e.g. the matrix multiplier input.

Parameters:
- LOCAL_BS_ID, 8'h02, block-select ID this instance accepts.
- BCAST_BS_ID, 8'hFF, broadcast ID, always accepted.
- LOCAL_FPGA_ID, 8'h00, FPGA ID checked only when the optional feature is compiled in.
- MAX_MSGS, 6, payload slots per packet; the maximum valid byte count is MAX_MSGS*4.

Ports:
- clk_200MHz  in  1  single clock.
- peripheral_aresetn  in  1  asynchronous active-low reset.
- fifo_dout  in  256  FWFT head word. Layout: BS_ID[255:248], FPGA_ID[247:240], PCKG_ID[239:224], TX_UID[223:216], RX_UID[215:208], VALID_PACKET_BYTES[207:192], msg0[191:160] .. msg5[31:0].
- fifo_not_empty  in  1  head word is valid.
- fifo_rd_en  out  1  pop strobe.
- hdr_valid  out  1  one-cycle pulse; header fields are valid.
- hdr_pckg_id  out  16  PCKG_ID of the accepted packet.
- hdr_tx_uid  out  8  TX_UID of the accepted packet.
- hdr_rx_uid  out  8  RX_UID of the accepted packet.
- hdr_bytes  out  16  VALID_PACKET_BYTES of the accepted packet.
- m_data  out  32  payload word.
- m_valid  out  1  payload word is valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  final payload word of the packet.
- seq_err  out  1  one-cycle pulse on a PCKG_ID discontinuity.
- pkt_count  out  32  accepted packets, saturating.
- drop_count  out  16  dropped packets, saturating.
- seq_err_count  out  16  sequence errors, saturating.

Behaviour:
- Reset (async assert, sync deassert inside block): state=IDLE. All outputs 0, including fifo_rd_en, m_valid, m_last, hdr_*, and all counters. expected_id=0, seq_synced=0.
- fifo_rd_en = (state==IDLE) & fifo_not_empty & peripheral_aresetn. This is combinational.
  - In that same cycle, fifo_dout is captured into pkt_reg.
  - At most one pop occurs per packet.
- IDLE -> DECODE on a pop.
- DECODE takes one cycle. A packet is accepted when all of the following hold:
  - (BS_ID==LOCAL_BS_ID or BS_ID==BCAST_BS_ID)
  - VALID_PACKET_BYTES[1:0]==0
  - VALID_PACKET_BYTES <= MAX_MSGS*4
- DECODE, rejected packet: drop_count+1, no hdr_valid, next state IDLE.
- DECODE, accepted packet:
  - hdr_valid=1 for 1 cycle, with hdr_* loaded from pkt_reg. pkt_count+1.
  - Sequence check: if seq_synced and PCKG_ID != expected_id, pulse seq_err and increment seq_err_count.
  - Then expected_id = PCKG_ID+1 (16-bit wrap, 16'hFFFF -> 0) and seq_synced=1. The first accepted packet after reset never raises seq_err.
  - If bytes==0: header-only packet, next state IDLE. Otherwise: word_cnt = bytes>>2, idx=0, next state STREAM.
- STREAM:
  - m_valid=1, m_data = msg[idx], where msg0 is bits 191:160 and idx increases toward msg5.
  - m_last = (idx==word_cnt-1).
  - On m_valid&m_ready: idx+1. If m_last, go to IDLE.
  - m_data, m_last and m_valid hold stable while m_ready=0.
- Latency: pop cycle N, hdr_valid at N+1, first m_valid at N+2.
- Best case throughput is one packet per (word_cnt+2) cycles. The FIFO is never popped while in DECODE or STREAM.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-packet: the in-flight packet is discarded, m_valid drops immediately (async), and no pop happens while reset is low.
- fifo_not_empty low in IDLE: remain in IDLE with rd_en=0.

Optional Feature:
- Macro PKT_RX_FPGA_ID_FILTER_EN.
- When defined: the accept condition additionally requires FPGA_ID==LOCAL_FPGA_ID, or BS_ID==BCAST_BS_ID (broadcast ignores FPGA_ID). A mismatch counts as a drop.
- When undefined: FPGA_ID is ignored entirely, with no extra logic.

Test Plan:
- 36 packets, BS_ID=0x02, PCKG_ID 0..35, bytes=24, all msgs=1, m_ready=1 -> 36 hdr_valid pulses, 216 words of value 1, m_last on every 6th word, pkt_count=36, seq_err_count=0, drop_count=0.
- Packet BS_ID=0x03 then BS_ID=0xFF (bytes=8) -> first popped and dropped (drop_count=1, no m_valid), second streams 2 words, pkt_count=1.
- PCKG_ID sequence 0,1,5,6 -> one seq_err pulse in the DECODE of ID 5, seq_err_count=1. Sequence 0xFFFF,0x0000 -> no error.
- bytes=10, bytes=28, bytes=0 -> first two dropped (drop_count=2); bytes=0 gives hdr_valid with no m_valid and returns to IDLE.
- bytes=24 with m_ready toggling 1,0,0,1,... -> m_data stable while stalled, exactly 6 transfers in order msg0..msg5, fifo_rd_en=0 throughout the stream.
- Reset pulsed low during the 3rd word of a packet -> outputs 0 immediately. After release, the next FIFO packet is decoded cleanly and its PCKG_ID raises no seq_err. With PKT_RX_FPGA_ID_FILTER_EN defined, FPGA_ID=0x01/BS_ID=0x02 is dropped.
